// File: rtl/seeg_ctrl_regs.sv
// Host-writable shadow/active parameter bank and command sequencer for the seeg stimulation core.
// Command writes are validated, optionally committed to the active set, then fan out into fixed-width pulses.
module seeg_ctrl_regs #(
    parameter int unsigned PULSE_CYCLES = 80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    input  logic [3:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic        wr_ready,
    input  logic        stim_busy,
    output logic [15:0] stim_pulse_length,
    output logic [15:0] stim_inter_bipulse_delay,
    output logic [15:0] stim_inter_pulse_delay,
    output logic [15:0] stim_inter_train_delay,
    output logic [15:0] stim_bipulses_per_train_count,
    output logic [15:0] stim_train_count,
    output logic [15:0] stim_charge_recovery_time,
    output logic [15:0] stim_mask_channel_positive,
    output logic [15:0] stim_mask_channel_negative,
    output logic [15:0] stim_current_step_size,
    output logic [15:0] stim_mask_probe_select,
    output logic [7:0]  stim_pulse_magnitude,
    output logic [1:0]  zcheck_scale,
    output logic        stim_rising_edge_first,
    output logic        stim_bipolar_mode,
    output logic        loopback_mode,
    output logic        record_start,
    output logic        record_stop,
    output logic        zcheck_start,
    output logic        stim_finite_mode_start,
    output logic        stim_infinite_mode_start,
    output logic        stim_infinite_mode_stop,
    output logic [3:0]  err
);

    typedef enum logic [1:0] {IDLE, CHECK, APPLY, PULSE} state_t;

    typedef struct packed {
        logic [15:0] pulse_length;
        logic [7:0]  magnitude;
        logic [15:0] inter_bipulse;
        logic [15:0] inter_pulse;
        logic [15:0] inter_train;
        logic [15:0] bipulses;
        logic [15:0] train_count;
        logic [15:0] charge_recovery;
        logic [15:0] mask_pos;
        logic [15:0] mask_neg;
        logic [15:0] step_size;
        logic        loopback;
        logic        bipolar;
        logic        rising_edge;
        logic [15:0] probe_select;
        logic [1:0]  zcheck_scale;
    } params_t;

    localparam params_t RST_PARAMS = '{
        pulse_length:    16'd1,
        magnitude:       8'd100,
        inter_bipulse:   16'd1,
        inter_pulse:     16'd1,
        inter_train:     16'd12,
        bipulses:        16'd4,
        train_count:     16'd4,
        charge_recovery: 16'd8,
        mask_pos:        16'h0080,
        mask_neg:        16'h8000,
        step_size:       16'd2,
        loopback:        1'b0,
        bipolar:         1'b1,
        rising_edge:     1'b1,
        probe_select:    16'h9AF0,
        zcheck_scale:    2'd3
    };

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES);

    state_t      state_q, state_d;
    params_t     shadow_q, shadow_d;
    params_t     active_q, active_d;
    logic [3:0]  err_q, err_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [5:0]  pend_q, pend_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        conflict;
    logic        invalid;
    logic        apply_rej;
    logic        start_drop;
    logic [5:0]  surv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= RST_PARAMS;
            active_q <= RST_PARAMS;
            err_q    <= '0;
            cmd_q    <= '0;
            pend_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            err_q    <= err_d;
            cmd_q    <= cmd_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        active_d   = active_q;
        err_d      = err_q;
        cmd_d      = cmd_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        apply_rej  = 1'b0;
        start_drop = 1'b0;
        surv       = '0;

        conflict = (cmd_q[1] & cmd_q[2]) | (cmd_q[4] & cmd_q[5]) | (cmd_q[5] & cmd_q[6]);
        invalid  = (shadow_q.pulse_length == 16'd0) || (shadow_q.bipulses == 16'd0) ||
                   (shadow_q.train_count == 16'd0) || (shadow_q.step_size > 16'd15) ||
                   ((shadow_q.mask_pos & shadow_q.mask_neg) != 16'd0);

        case (state_q)
            IDLE: begin
                if (wr_valid) begin
                    case (wr_addr)
                        4'h0: shadow_d.pulse_length    = wr_data;
                        4'h1: shadow_d.magnitude       = wr_data[7:0];
                        4'h2: shadow_d.inter_bipulse   = wr_data;
                        4'h3: shadow_d.inter_pulse     = wr_data;
                        4'h4: shadow_d.inter_train     = wr_data;
                        4'h5: shadow_d.bipulses        = wr_data;
                        4'h6: shadow_d.train_count     = wr_data;
                        4'h7: shadow_d.charge_recovery = wr_data;
                        4'h8: shadow_d.mask_pos        = wr_data;
                        4'h9: shadow_d.mask_neg        = wr_data;
                        4'hA: shadow_d.step_size       = wr_data;
                        4'hB: {shadow_d.loopback, shadow_d.bipolar, shadow_d.rising_edge} = wr_data[2:0];
                        4'hC: shadow_d.probe_select    = wr_data;
                        4'hD: shadow_d.zcheck_scale    = wr_data[1:0];
                        4'hE: err_d[0]                 = 1'b1;
                        default: begin
                            cmd_d   = wr_data[7:0];
                            state_d = CHECK;
                        end
                    endcase
                end
            end
            CHECK: begin
                if (cmd_q[7]) begin
                    err_d = '0;
                end
                if (conflict) begin
                    err_d[3] = 1'b1;
                    pend_d   = '0;
                    state_d  = IDLE;
                end else begin
                    if (cmd_q[0]) begin
                        if (invalid) begin
                            err_d[1]  = 1'b1;
                            apply_rej = 1'b1;
                        end else if (stim_busy) begin
                            err_d[2]  = 1'b1;
                            apply_rej = 1'b1;
                        end
                    end
                    // A rejected apply takes its starts down with it without a second error flag.
                    if (cmd_q[4] | cmd_q[5]) begin
                        if (apply_rej) begin
                            start_drop = 1'b1;
                        end else if (stim_busy) begin
                            err_d[2]   = 1'b1;
                            start_drop = 1'b1;
                        end
                    end
                    surv   = {cmd_q[6], cmd_q[5] & ~start_drop, cmd_q[4] & ~start_drop,
                              cmd_q[3], cmd_q[2], cmd_q[1]};
                    pend_d = surv;
                    if (cmd_q[0] && !apply_rej) begin
                        active_d = shadow_q;
                        state_d  = APPLY;
                    end else if (surv != '0) begin
                        cnt_d   = PULSE_LOAD;
                        state_d = PULSE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            APPLY: begin
                if (pend_q != '0) begin
                    cnt_d   = PULSE_LOAD;
                    state_d = PULSE;
                end else begin
                    state_d = IDLE;
                end
            end
            PULSE: begin
                if (cnt_q <= 8'd1) begin
                    cnt_d   = '0;
                    pend_d  = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_ready = (state_q == IDLE);
    assign err      = err_q;

    assign record_start             = (state_q == PULSE) & pend_q[0];
    assign record_stop              = (state_q == PULSE) & pend_q[1];
    assign zcheck_start             = (state_q == PULSE) & pend_q[2];
    assign stim_finite_mode_start   = (state_q == PULSE) & pend_q[3];
    assign stim_infinite_mode_start = (state_q == PULSE) & pend_q[4];
    assign stim_infinite_mode_stop  = (state_q == PULSE) & pend_q[5];

    assign stim_pulse_length             = active_q.pulse_length;
    assign stim_pulse_magnitude          = active_q.magnitude;
    assign stim_inter_bipulse_delay      = active_q.inter_bipulse;
    assign stim_inter_pulse_delay        = active_q.inter_pulse;
    assign stim_inter_train_delay        = active_q.inter_train;
    assign stim_bipulses_per_train_count = active_q.bipulses;
    assign stim_train_count              = active_q.train_count;
    assign stim_charge_recovery_time     = active_q.charge_recovery;
    assign stim_mask_channel_positive    = active_q.mask_pos;
    assign stim_mask_channel_negative    = active_q.mask_neg;
    assign stim_current_step_size        = active_q.step_size;
    assign loopback_mode                 = active_q.loopback;
    assign stim_bipolar_mode             = active_q.bipolar;
    assign stim_rising_edge_first        = active_q.rising_edge;
    assign stim_mask_probe_select        = active_q.probe_select;
    assign zcheck_scale                  = active_q.zcheck_scale;

endmodule

// File: tb/tb_seeg_ctrl_regs.sv
// Randomized bench for seeg_ctrl_regs against a register-array reference model.
module tb_seeg_ctrl_regs;

    localparam int PC = 80;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_valid = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ready;
    logic        stim_busy = 1'b0;
    logic [15:0] stim_pulse_length, stim_inter_bipulse_delay, stim_inter_pulse_delay;
    logic [15:0] stim_inter_train_delay, stim_bipulses_per_train_count, stim_train_count;
    logic [15:0] stim_charge_recovery_time, stim_mask_channel_positive, stim_mask_channel_negative;
    logic [15:0] stim_current_step_size, stim_mask_probe_select;
    logic [7:0]  stim_pulse_magnitude;
    logic [1:0]  zcheck_scale;
    logic        stim_rising_edge_first, stim_bipolar_mode, loopback_mode;
    logic        record_start, record_stop, zcheck_start;
    logic        stim_finite_mode_start, stim_infinite_mode_start, stim_infinite_mode_stop;
    logic [3:0]  err;

    int tests = 0;
    int fails = 0;

    // Model state: index = register address, values already masked to field width.
    logic [13:0][15:0] sh_m, act_m;
    logic [3:0]        err_m;

    seeg_ctrl_regs #(.PULSE_CYCLES(PC)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
        .stim_busy(stim_busy),
        .stim_pulse_length(stim_pulse_length),
        .stim_inter_bipulse_delay(stim_inter_bipulse_delay),
        .stim_inter_pulse_delay(stim_inter_pulse_delay),
        .stim_inter_train_delay(stim_inter_train_delay),
        .stim_bipulses_per_train_count(stim_bipulses_per_train_count),
        .stim_train_count(stim_train_count),
        .stim_charge_recovery_time(stim_charge_recovery_time),
        .stim_mask_channel_positive(stim_mask_channel_positive),
        .stim_mask_channel_negative(stim_mask_channel_negative),
        .stim_current_step_size(stim_current_step_size),
        .stim_mask_probe_select(stim_mask_probe_select),
        .stim_pulse_magnitude(stim_pulse_magnitude),
        .zcheck_scale(zcheck_scale),
        .stim_rising_edge_first(stim_rising_edge_first),
        .stim_bipolar_mode(stim_bipolar_mode),
        .loopback_mode(loopback_mode),
        .record_start(record_start), .record_stop(record_stop), .zcheck_start(zcheck_start),
        .stim_finite_mode_start(stim_finite_mode_start),
        .stim_infinite_mode_start(stim_infinite_mode_start),
        .stim_infinite_mode_stop(stim_infinite_mode_stop),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [13:0][15:0] reset_vals();
        logic [13:0][15:0] r;
        r[0] = 16'd1;   r[1] = 16'd100; r[2] = 16'd1;  r[3] = 16'd1;
        r[4] = 16'd12;  r[5] = 16'd4;   r[6] = 16'd4;  r[7] = 16'd8;
        r[8] = 16'h0080; r[9] = 16'h8000; r[10] = 16'd2;
        r[11] = 16'h0003; r[12] = 16'h9AF0; r[13] = 16'd3;
        return r;
    endfunction

    function automatic logic [223:0] dut_active();
        return {16'(zcheck_scale), stim_mask_probe_select,
                16'({loopback_mode, stim_bipolar_mode, stim_rising_edge_first}),
                stim_current_step_size, stim_mask_channel_negative, stim_mask_channel_positive,
                stim_charge_recovery_time, stim_train_count, stim_bipulses_per_train_count,
                stim_inter_train_delay, stim_inter_pulse_delay, stim_inter_bipulse_delay,
                16'(stim_pulse_magnitude), stim_pulse_length};
    endfunction

    function automatic logic [5:0] pulses();
        return {stim_infinite_mode_stop, stim_infinite_mode_start, stim_finite_mode_start,
                zcheck_start, record_stop, record_start};
    endfunction

    function automatic void model_reset();
        sh_m  = reset_vals();
        act_m = reset_vals();
        err_m = '0;
    endfunction

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!wr_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) check("wr_ready_timeout", 0, 1);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        wait_ready();
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_valid = 1'b0;
        if (a == 4'hE) err_m[0] = 1'b1;
        else if (a == 4'h1) sh_m[1] = {8'h00, d[7:0]};
        else if (a == 4'hB) sh_m[11] = {13'd0, d[2:0]};
        else if (a == 4'hD) sh_m[13] = {14'd0, d[1:0]};
        else if (a != 4'hF) sh_m[a] = d;
    endtask

    task automatic cmd(input logic [15:0] d);
        logic [7:0]   c;
        logic [5:0]   exp_mask, seen, vec;
        logic [223:0] new_act;
        bit           conflict, invalid, rej, st_ok, apply_ok, bad_vec, changed;
        int           rise, ch, hi;
        c = d[7:0];
        if (c[7]) err_m = '0;
        conflict = (c[1] && c[2]) || (c[4] && c[5]) || (c[5] && c[6]);
        invalid  = sh_m[0] == 0 || sh_m[5] == 0 || sh_m[6] == 0 || sh_m[10] > 15 ||
                   (sh_m[8] & sh_m[9]) != 0;
        apply_ok = 0; exp_mask = '0;
        if (conflict) begin
            err_m[3] = 1'b1;
        end else begin
            rej = 0;
            if (c[0]) begin
                if (invalid) begin err_m[1] = 1'b1; rej = 1; end
                else if (stim_busy) begin err_m[2] = 1'b1; rej = 1; end
            end
            apply_ok = c[0] && !rej;
            st_ok = 1;
            if (c[4] || c[5]) begin
                if (c[0] && rej) st_ok = 0;
                else if (stim_busy) begin err_m[2] = 1'b1; st_ok = 0; end
            end
            exp_mask = {c[6], c[5] & st_ok, c[4] & st_ok, c[3], c[2], c[1]};
        end
        new_act = act_m;
        if (apply_ok) new_act = sh_m;
        changed = apply_ok && (new_act != act_m);
        act_m = new_act;

        wait_ready();
        wr_valid = 1'b1; wr_addr = 4'hF; wr_data = d;
        rise = -1; ch = -1; hi = 0; seen = '0; bad_vec = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (n == 1) wr_valid = 1'b0;
            vec = pulses();
            if (vec != '0) begin
                if (rise < 0) rise = n;
                hi++;
                seen |= vec;
                if (vec != exp_mask) bad_vec = 1;
            end
            if (changed && ch < 0 && dut_active() == new_act) ch = n;
            if (wr_ready) break;
        end
        check("cmd_idle_return", wr_ready, 1);
        check("pulse_mask", seen, exp_mask);
        check("pulse_len", hi, (exp_mask != '0) ? PC : 0);
        check("pulse_simultaneous", bad_vec, 0);
        if (changed && exp_mask != '0) check("apply_lead", rise - ch, 1);
        check("err", err, err_m);
        check("active", dut_active(), act_m);
    endtask

    task automatic hold_valid_zcheck();
        int low = 0, edges = 0, n = 0;
        logic prev;
        wait_ready();
        wr_valid = 1'b1; wr_addr = 4'hF; wr_data = 16'h0008;
        prev = 1'b0;
        @(negedge clk);
        while (!wr_ready && n < 400) begin
            low++;
            if (zcheck_start && !prev) edges++;
            prev = zcheck_start;
            @(negedge clk);
            n++;
        end
        wr_valid = 1'b0;
        check("hold_ready_low", low, PC + 1);
        check("hold_zcheck_edges", edges, 1);
        check("hold_err", err, err_m);
    endtask

    task automatic reset_mid_pulse();
        int n = 0, seen = 0;
        wr(4'h0, 16'd9);
        wr(4'hE, 16'h0);
        cmd(16'h0001);
        wait_ready();
        wr_valid = 1'b1; wr_addr = 4'hF; wr_data = 16'h0008;
        @(negedge clk);
        wr_valid = 1'b0;
        while (!zcheck_start && n < 20) begin @(negedge clk); n++; end
        check("rst_pulse_started", zcheck_start, 1);
        repeat (39) @(negedge clk);
        check("rst_pulse_still_high", zcheck_start, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_pulses_drop", pulses(), 6'd0);
        check("rst_err", err, 4'd0);
        check("rst_active", dut_active(), reset_vals());
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (pulses() != '0) seen++;
        end
        check("rst_no_resume", seen, 0);
        check("rst_ready", wr_ready, 1);
    endtask

    initial begin
        logic [3:0]  a;
        logic [15:0] d;
        int          r;
        model_reset();
        #23 rst = 1'b0;
        @(negedge clk);
        check("reset_active", dut_active(), reset_vals());
        check("reset_err", err, 4'd0);
        check("reset_pulses", pulses(), 6'd0);
        check("reset_ready", wr_ready, 1);

        wr(4'h0, 16'd5);
        cmd(16'h0011);
        wr(4'h8, 16'h8000);
        cmd(16'h0001);
        stim_busy = 1'b1;
        cmd(16'h0020);
        cmd(16'h0040);
        stim_busy = 1'b0;
        wr(4'h8, 16'h0080);
        cmd(16'h0080);
        cmd(16'h0006);
        cmd(16'h0080);
        hold_valid_zcheck();

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 9);
            stim_busy = ($urandom_range(0, 3) == 0);
            if (r < 5) begin
                a = 4'($urandom_range(0, 13));
                case (a)
                    4'h0, 4'h5, 4'h6: d = 16'($urandom_range(0, 3));
                    4'hA:             d = 16'($urandom_range(0, 20));
                    4'h8, 4'h9:       d = 16'(1 << $urandom_range(0, 15));
                    default:          d = 16'($urandom);
                endcase
                wr(a, d);
            end else if (r == 5) begin
                wr(4'hE, 16'($urandom));
            end else begin
                d = 16'($urandom);
                d[7] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 1) == 1) d[0] = 1'b1;
                cmd(d);
            end
        end
        stim_busy = 1'b0;
        reset_mid_pulse();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seeg_ctrl_regs.md
SEEG_CTRL_REGS -- requirements
Module: seeg_ctrl_regs

Interface
REQ-001 SHALL have parameter PULSE_CYCLES, default 80: width in clk cycles of every command pulse output (must be 1..255).
REQ-002 SHALL have ports: clk in 1 (single clock); rst in 1 (asynchronous, active-high reset).
REQ-003 SHALL have ports: wr_valid in 1; wr_addr in 4; wr_data in 16; wr_ready out 1 (host write channel).
REQ-004 SHALL have input stim_busy, 1 bit: high while the downstream seeg core is delivering stimulation.
REQ-005 SHALL have active parameter outputs: stim_pulse_length, stim_inter_bipulse_delay, stim_inter_pulse_delay, stim_inter_train_delay, stim_bipulses_per_train_count, stim_train_count, stim_charge_recovery_time, stim_mask_channel_positive, stim_mask_channel_negative, stim_current_step_size, stim_mask_probe_select (16 bits each), stim_pulse_magnitude (8), zcheck_scale (2), stim_rising_edge_first, stim_bipolar_mode, loopback_mode (1 each).
REQ-006 SHALL have 1-bit pulse outputs: record_start, record_stop, zcheck_start, stim_finite_mode_start, stim_infinite_mode_start, stim_infinite_mode_stop.
REQ-007 SHALL have output err, 4 bits, sticky: [0] bad address, [1] parameter invalid, [2] busy reject, [3] command conflict.

Function
REQ-008 SHALL accept a write on the rising clk edge where wr_valid and wr_ready are both high; wr_valid may stay high across cycles without duplicate acceptance unless wr_ready is high.
REQ-009 SHALL store written data into a shadow set: 0x0 pulse_length, 0x1 magnitude=data[7:0], 0x2 inter_bipulse, 0x3 inter_pulse, 0x4 inter_train, 0x5 bipulses, 0x6 train_count, 0x7 charge_recovery, 0x8 mask_pos, 0x9 mask_neg, 0xA step_size, 0xB {loopback,bipolar,rising_edge}=data[2:0], 0xC probe_select, 0xD zcheck_scale=data[1:0].
REQ-010 SHALL treat 0xE as unmapped: accept, discard, set err[0].
REQ-011 SHALL treat 0xF as command register: bit0 apply, bit1 record_start, bit2 record_stop, bit3 zcheck_start, bit4 finite_start, bit5 infinite_start, bit6 infinite_stop, bit7 clear err; bits 15:8 ignored.
REQ-012 SHALL run FSM IDLE -> CHECK -> (APPLY) -> PULSE -> IDLE on a command write; wr_ready high only in IDLE; shadow writes stay in IDLE.
REQ-013 CHECK (1 cycle): if bit7 set, clear err this cycle before evaluating new errors; errors raised in the same command then set.
REQ-014 Apply SHALL be rejected (err[1], active outputs unchanged) if any of pulse_length, bipulses, train_count equals 0, step_size > 15, or (mask_pos & mask_neg) != 0.
REQ-015 Apply SHALL be rejected with err[2] if stim_busy is high at CHECK; validation error takes priority (only err[1] set).
REQ-016 Accepted apply SHALL copy all shadow registers to active outputs in the APPLY cycle, exactly one cycle before any pulse from the same command rises.
REQ-017 finite_start or infinite_start SHALL be dropped with err[2] if stim_busy high at CHECK; infinite_stop, record and zcheck bits are never busy-rejected.
REQ-018 If bit1 and bit2 both set, or bit4 and bit5 both set, or bit5 and bit6 both set, the entire command (including apply) SHALL be dropped, err[3] set, FSM returns to IDLE without PULSE.
REQ-019 A start bit in a command whose apply was rejected SHALL also be dropped.
REQ-020 PULSE SHALL drive all surviving pulse bits high simultaneously for exactly PULSE_CYCLES cycles via an 8-bit down-counter, then return to IDLE; a command with no surviving pulse bits skips PULSE.
REQ-021 Reading back is not supported; shadow contents persist until overwritten or reset.

Reset
REQ-022 rst SHALL asynchronously force: FSM IDLE, wr_ready 1 after release, all pulse outputs 0, err 0, counter 0.
REQ-023 Reset values of shadow and active: pulse_length 1, magnitude 100, inter_bipulse 1, inter_pulse 1, inter_train 12, bipulses 4, train_count 4, charge_recovery 8, mask_pos 0x0080, mask_neg 0x8000, step_size 2, probe_select 0x9AF0, zcheck_scale 3, rising_edge 1, bipolar 1, loopback 0.
REQ-024 rst asserted mid-PULSE SHALL immediately drop pulses; no pulse resumes after release.

Verification
REQ-025 Write 0x0=5, 0xF=0x0011, stim_busy 0 -> stim_pulse_length 5 one cycle before stim_finite_mode_start high for exactly 80 cycles; err 0.
REQ-026 Write 0x8=0x8000 then 0xF=0x0001 -> err=0x2, stim_mask_channel_positive stays 0x0080.
REQ-027 stim_busy 1, write 0xF=0x0020 -> no infinite_start pulse, err[2]=1; then 0xF=0x0040 -> infinite_stop pulses 80 cycles.
REQ-028 Write 0xF=0x0006 -> no pulses, err=0x8; then 0xF=0x0080 -> err=0.
REQ-029 Hold wr_valid high through PULSE with 0xF=0x0008 -> wr_ready low 80+ cycles, exactly one zcheck_start pulse.
REQ-030 Assert rst at PULSE cycle 40 -> pulse outputs 0 same cycle, all outputs at REQ-023 values.
